// File: rtl/micro_core_param.sv
// Parameterised accumulator micro-core: 16-opcode ISA, one instruction per cycle,
// call stack with sticky over/underflow flag and a hardware loop counter.
module micro_core_param #(
    parameter int DW = 4,
    parameter int PW = 8,
    parameter int SD = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic [DW+3:0] pm_data,
    input  logic [DW-1:0] i_pins,
    output logic [PW-1:0] pm_address,
    output logic [PW-1:0] pc,
    output logic [DW+3:0] ir,
    output logic [DW-1:0] acc,
    output logic [DW-1:0] o_reg,
    output logic          zero_flag,
    output logic          carry_flag,
    output logic          halted,
    output logic          stack_err
);

    localparam int SPW = $clog2(SD + 1);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_XOR  = 4'h5,
        OP_IN   = 4'h6,
        OP_OUT  = 4'h7,
        OP_JMP  = 4'h8,
        OP_JNZ  = 4'h9,
        OP_CALL = 4'hA,
        OP_RET  = 4'hB,
        OP_LDL  = 4'hC,
        OP_DJNZ = 4'hD,
        OP_NOP2 = 4'hE,
        OP_HALT = 4'hF
    } op_e;

    op_e            op;
    logic [DW-1:0]  imm;
    logic [PW-1:0]  pc_inc;
    logic [PW-1:0]  target;
    logic [DW:0]    sum;
    logic [DW:0]    diff;
    logic [DW-1:0]  lc;
    logic [SPW-1:0] sp;
    logic           run;
    logic           stk_full;
    logic           stk_empty;
    logic           push_en;

    // Sized to a power of two so sp indexes it without width games.
    logic [PW-1:0]  stack [0:(1<<SPW)-1];

    assign op        = op_e'(pm_data[DW+3:DW]);
    assign imm       = pm_data[DW-1:0];
    assign pc_inc    = pc + PW'(1);
    assign sum       = {1'b0, acc} + {1'b0, imm};
    assign diff      = {1'b0, acc} - {1'b0, imm};
    assign run       = !stall && !halted;
    assign stk_full  = (sp == SPW'(SD));
    assign stk_empty = (sp == '0);
    assign push_en   = reset && run && (op == OP_CALL) && !stk_full;
    assign pm_address = pc;

    generate
        if (PW == DW) begin : g_tgt_flat
            assign target = imm;
        end else begin : g_tgt_page
            assign target = {pc[PW-1:DW], imm};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push_en) begin
            stack[sp] <= pc_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= '0;
            ir         <= '0;
            acc        <= '0;
            o_reg      <= '0;
            lc         <= '0;
            sp         <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            halted     <= 1'b0;
            stack_err  <= 1'b0;
        end else if (run) begin
            ir <= pm_data;
            pc <= pc_inc;
            unique case (op)
                OP_LDI: begin
                    acc       <= imm;
                    zero_flag <= (imm == '0);
                end
                OP_ADD: begin
                    acc        <= sum[DW-1:0];
                    carry_flag <= sum[DW];
                    zero_flag  <= (sum[DW-1:0] == '0);
                end
                OP_SUB: begin
                    acc        <= diff[DW-1:0];
                    carry_flag <= diff[DW];
                    zero_flag  <= (diff[DW-1:0] == '0);
                end
                OP_AND: begin
                    acc       <= acc & imm;
                    zero_flag <= ((acc & imm) == '0);
                end
                OP_XOR: begin
                    acc       <= acc ^ imm;
                    zero_flag <= ((acc ^ imm) == '0);
                end
                OP_IN: begin
                    acc       <= i_pins;
                    zero_flag <= (i_pins == '0);
                end
                OP_OUT: o_reg <= acc;
                OP_JMP: pc <= target;
                OP_JNZ: begin
                    if (!zero_flag) pc <= target;
                end
                OP_CALL: begin
                    if (!stk_full) begin
                        sp <= sp + SPW'(1);
                        pc <= target;
                    end else begin
                        stack_err <= 1'b1;
                    end
                end
                OP_RET: begin
                    if (!stk_empty) begin
                        pc <= stack[sp - SPW'(1)];
                        sp <= sp - SPW'(1);
                    end else begin
                        stack_err <= 1'b1;
                    end
                end
                OP_LDL: lc <= imm;
                // Test-before-decrement: LDL n gives n extra loop passes.
                OP_DJNZ: begin
                    if (lc != '0) begin
                        lc <= lc - DW'(1);
                        pc <= target;
                    end
                end
                OP_HALT: begin
                    halted <= 1'b1;
                    pc     <= pc;
                end
                OP_NOP, OP_NOP2: ;
            endcase
        end
    end

endmodule

// File: tb/tb_micro_core_param.sv
// Bench for micro_core_param: directed programs plus random programs,
// checked every cycle against an instruction-level interpreter.
module tb_micro_core_param;

    localparam int DW = 4;
    localparam int PW = 8;
    localparam int SD = 2;
    localparam int M  = 1 << DW;
    localparam int P  = 1 << PW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          stall = 1'b0;
    logic [DW+3:0] pm_data;
    logic [DW-1:0] i_pins = '0;
    logic [PW-1:0] pm_address;
    logic [PW-1:0] pc;
    logic [DW+3:0] ir;
    logic [DW-1:0] acc;
    logic [DW-1:0] o_reg;
    logic          zero_flag;
    logic          carry_flag;
    logic          halted;
    logic          stack_err;

    logic [7:0] prog [P];

    int n_cmp = 0;
    int n_bad = 0;

    // Interpreter state
    int m_pc, m_ir, m_acc, m_o, m_lc;
    bit m_z, m_c, m_h, m_err;
    int m_stk[$];

    micro_core_param #(.DW(DW), .PW(PW), .SD(SD)) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .pm_data(pm_data),
        .i_pins(i_pins),
        .pm_address(pm_address),
        .pc(pc),
        .ir(ir),
        .acc(acc),
        .o_reg(o_reg),
        .zero_flag(zero_flag),
        .carry_flag(carry_flag),
        .halted(halted),
        .stack_err(stack_err)
    );

    assign pm_data = prog[pm_address];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_acc = 0; m_o = 0; m_lc = 0;
        m_z = 0; m_c = 0; m_h = 0; m_err = 0;
        m_stk.delete();
    endtask

    task automatic model_step();
        int op, imm, npc, tgt, r;
        if (stall || m_h) return;
        op   = prog[m_pc] / M;
        imm  = prog[m_pc] % M;
        m_ir = prog[m_pc];
        npc  = (m_pc + 1) % P;
        tgt  = (m_pc / M) * M + imm;
        case (op)
            1: begin m_acc = imm; m_z = (m_acc == 0); end
            2: begin
                r = m_acc + imm;
                m_c = (r >= M); m_acc = r % M; m_z = (m_acc == 0);
            end
            3: begin
                m_c = (m_acc < imm);
                m_acc = (m_acc - imm + M) % M; m_z = (m_acc == 0);
            end
            4: begin m_acc = m_acc & imm; m_z = (m_acc == 0); end
            5: begin m_acc = m_acc ^ imm; m_z = (m_acc == 0); end
            6: begin m_acc = int'(i_pins); m_z = (m_acc == 0); end
            7: m_o = m_acc;
            8: npc = tgt;
            9: if (!m_z) npc = tgt;
            10: begin
                if (m_stk.size() < SD) begin
                    m_stk.push_back(npc); npc = tgt;
                end else m_err = 1;
            end
            11: begin
                if (m_stk.size() > 0) npc = m_stk.pop_back();
                else m_err = 1;
            end
            12: m_lc = imm;
            13: if (m_lc != 0) begin m_lc--; npc = tgt; end
            15: begin m_h = 1; npc = m_pc; end
            default: ;
        endcase
        m_pc = npc;
    endtask

    task automatic check_all();
        chk("pc", pc, m_pc);
        chk("pm_address", pm_address, m_pc);
        chk("ir", ir, m_ir);
        chk("acc", acc, m_acc);
        chk("o_reg", o_reg, m_o);
        chk("zero_flag", zero_flag, m_z);
        chk("carry_flag", carry_flag, m_c);
        chk("halted", halted, m_h);
        chk("stack_err", stack_err, m_err);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Pulse reset mid-cycle and confirm the asynchronous clear.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_pc", pc, 0);
        chk("rst_acc", acc, 0);
        chk("rst_o_reg", o_reg, 0);
        chk("rst_ir", ir, 0);
        chk("rst_flags", {zero_flag, carry_flag, halted, stack_err}, 0);
        chk("rst_lc", dut.lc, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < P; i++) prog[i] = 8'h00;
    endtask

    initial begin
        clear_prog();
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Add with carry, OUT, HALT holds pc
        prog[0] = 8'h19; prog[1] = 8'h28; prog[2] = 8'h70; prog[3] = 8'hF0;
        repeat (6) tick();
        chk("t1_acc", acc, 1);
        chk("t1_carry", carry_flag, 1);
        chk("t1_zero", zero_flag, 0);
        chk("t1_o_reg", o_reg, 1);
        chk("t1_halted", halted, 1);
        chk("t1_pc", pc, 3);

        // SUB to zero, JNZ falls through
        do_reset();
        clear_prog();
        prog[0] = 8'h13; prog[1] = 8'h33; prog[2] = 8'h90; prog[3] = 8'h70;
        prog[4] = 8'hF0;
        repeat (3) tick();
        chk("t2_jnz_fall", pc, 3);
        tick();
        chk("t2_zero", zero_flag, 1);
        chk("t2_o_reg", o_reg, 0);
        chk("t2_pc", pc, 4);

        // DJNZ loop: body runs 4 times
        do_reset();
        clear_prog();
        prog[0] = 8'hC3; prog[1] = 8'h21; prog[2] = 8'hD1; prog[3] = 8'hF0;
        repeat (11) tick();
        chk("t3_body_count", acc, 4);
        chk("t3_lc", dut.lc, 0);
        chk("t3_pc", pc, 3);
        chk("t3_halted", halted, 1);

        // Nested calls with SD=2: overflow then underflow
        do_reset();
        clear_prog();
        prog[0] = 8'hA4; prog[4] = 8'hA8; prog[8] = 8'hAC;
        prog[9] = 8'hB0; prog[5] = 8'hB0; prog[1] = 8'hB0; prog[2] = 8'hF0;
        repeat (2) tick();
        chk("t4_depth2", pc, 8);
        chk("t4_no_err", stack_err, 0);
        tick();
        chk("t4_ovf_pc", pc, 9);
        chk("t4_ovf_err", stack_err, 1);
        tick();
        chk("t4_ret1", pc, 5);
        tick();
        chk("t4_ret2", pc, 1);
        tick();
        chk("t4_unf_pc", pc, 2);
        chk("t4_unf_err", stack_err, 1);
        tick();
        chk("t4_halted", halted, 1);

        // Paged jump and pc wrap
        do_reset();
        clear_prog();
        prog[8'h23] = 8'h85;
        for (int i = 0; i < 64 && m_pc != 8'h23; i++) tick();
        tick();
        chk("t5_jmp_page", pc, 8'h25);
        for (int i = 0; i < 300 && m_pc != 8'hFF; i++) tick();
        chk("t5_at_ff", pc, 8'hFF);
        tick();
        chk("t5_wrap", pc, 8'h00);

        // Stall freezes everything, then reset aborts mid-program
        do_reset();
        clear_prog();
        prog[0] = 8'h15; prog[1] = 8'h70; prog[2] = 8'h23; prog[3] = 8'h80;
        repeat (3) tick();
        stall = 1'b1;
        i_pins = 4'hA;
        repeat (3) tick();
        chk("t6_stall_pc", pc, 3);
        chk("t6_stall_acc", acc, 8);
        chk("t6_stall_ir", ir, 8'h23);
        stall = 1'b0;
        tick();
        chk("t6_resume", pc, 0);
        do_reset();
        tick();
        chk("t6_restart_pc", pc, 1);
        chk("t6_restart_acc", acc, 5);

        // Random programs, inputs and stalls
        for (int run = 0; run < 4; run++) begin
            for (int i = 0; i < P; i++) begin
                prog[i] = 8'($urandom);
                if (prog[i][7:4] == 4'hF && $urandom_range(0, 3) != 0)
                    prog[i][7:4] = 4'h2;
            end
            do_reset();
            for (int c = 0; c < 300; c++) begin
                stall  = ($urandom_range(0, 4) == 0);
                i_pins = 4'($urandom);
                if (m_h && $urandom_range(0, 3) == 0) begin
                    stall = 1'b0;
                    do_reset();
                end
                tick();
            end
        end
        stall = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
